// File: rtl/arbiter_lv1_lv2.sv
// ============================================================================
// Module   : arbiter_lv1_lv2
// Brief    : Round-robin arbiter for the shared lv1-lv2 bus (processor + snoop)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbiter_lv1_lv2 #(
  parameter int NUM_CORES = 4,
  parameter int TIMEOUT   = 1024,
  parameter int TMR_WID   = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CORES-1:0] bus_lv1_lv2_req_proc_dl,
  input  logic [NUM_CORES-1:0] bus_lv1_lv2_req_proc_il,
  input  logic [NUM_CORES-1:0] bus_lv1_lv2_req_snoop,
  output logic [NUM_CORES-1:0] bus_lv1_lv2_gnt_proc_dl,
  output logic [NUM_CORES-1:0] bus_lv1_lv2_gnt_proc_il,
  output logic [NUM_CORES-1:0] bus_lv1_lv2_gnt_snoop,
  output logic                 bus_busy,
  output logic                 arb_timeout
);

  localparam int NP = 2 * NUM_CORES;
  localparam int PW = (NP > 1) ? $clog2(NP) : 1;
  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [TMR_WID-1:0] TMR_MAX = TMR_WID'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PROC       = 2'd1,
    PROC_SNOOP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [CW-1:0]        snooper_q, snooper_d;
  logic [PW-1:0]        proc_ptr_q, proc_ptr_d;
  logic [CW-1:0]        snoop_ptr_q, snoop_ptr_d;
  logic [NP-1:0]        pgnt_q, pgnt_d;
  logic [NUM_CORES-1:0] sgnt_q, sgnt_d;
  logic                 busy_q;
  logic [TMR_WID-1:0]   tmr_q, tmr_d;
  logic                 timeout_q, timeout_d;

  logic [NP-1:0]        req_proc;
  logic [NUM_CORES-1:0] snoop_elig;
  logic [CW-1:0]        owner_core;
  logic                 proc_found, snoop_found;
  logic [PW-1:0]        proc_pick;
  logic [CW-1:0]        snoop_pick;
  logic                 gnt_change;
  logic                 gnt_held;

  function automatic logic [PW-1:0] add_p(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NP) s = s - NP;
    return s[PW-1:0];
  endfunction

  function automatic logic [CW-1:0] add_c(input logic [CW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_CORES) s = s - NUM_CORES;
    return s[CW-1:0];
  endfunction

  // Flat processor index: even = data cache, odd = instruction cache of core p/2
  always_comb begin
    req_proc = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      req_proc[2*c]   = bus_lv1_lv2_req_proc_dl[c];
      req_proc[2*c+1] = bus_lv1_lv2_req_proc_il[c];
    end
  end

  assign owner_core = CW'(owner_q >> 1);

  // A dl owner cannot be snooped by its own core's data cache
  always_comb begin
    snoop_elig = bus_lv1_lv2_req_snoop;
    if (!owner_q[0]) snoop_elig[owner_core] = 1'b0;
  end

  always_comb begin
    proc_found = 1'b0;
    proc_pick  = proc_ptr_q;
    for (int i = 0; i < NP; i++) begin
      if (!proc_found && req_proc[add_p(proc_ptr_q, i)]) begin
        proc_found = 1'b1;
        proc_pick  = add_p(proc_ptr_q, i);
      end
    end
  end

  always_comb begin
    snoop_found = 1'b0;
    snoop_pick  = snoop_ptr_q;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!snoop_found && snoop_elig[add_c(snoop_ptr_q, i)]) begin
        snoop_found = 1'b1;
        snoop_pick  = add_c(snoop_ptr_q, i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    snooper_d   = snooper_q;
    proc_ptr_d  = proc_ptr_q;
    snoop_ptr_d = snoop_ptr_q;
    pgnt_d      = pgnt_q;
    sgnt_d      = sgnt_q;
    case (state_q)
      IDLE: begin
        if (proc_found) begin
          owner_d = proc_pick;
          pgnt_d  = {{(NP-1){1'b0}}, 1'b1} << proc_pick;
          state_d = PROC;
        end
      end
      PROC: begin
        if (!req_proc[owner_q]) begin
          pgnt_d     = '0;
          proc_ptr_d = add_p(owner_q, 1);
          state_d    = IDLE;
        end else if (snoop_found) begin
          snooper_d = snoop_pick;
          sgnt_d    = {{(NUM_CORES-1){1'b0}}, 1'b1} << snoop_pick;
          state_d   = PROC_SNOOP;
        end
      end
      PROC_SNOOP: begin
        // Owner release takes priority and ends the snoop on the same edge
        if (!req_proc[owner_q]) begin
          pgnt_d      = '0;
          sgnt_d      = '0;
          proc_ptr_d  = add_p(owner_q, 1);
          snoop_ptr_d = add_c(snooper_q, 1);
          state_d     = IDLE;
        end else if (!bus_lv1_lv2_req_snoop[snooper_q]) begin
          sgnt_d      = '0;
          snoop_ptr_d = add_c(snooper_q, 1);
          state_d     = PROC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt_change = (pgnt_d != pgnt_q) || (sgnt_d != sgnt_q);
  assign gnt_held   = (|pgnt_q) || (|sgnt_q);

  always_comb begin
    tmr_d = tmr_q;
    if (gnt_change)                    tmr_d = '0;
    else if (gnt_held && tmr_q != TMR_MAX) tmr_d = tmr_q + 1'b1;
    timeout_d = timeout_q | (tmr_d == TMR_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      snooper_q   <= '0;
      proc_ptr_q  <= '0;
      snoop_ptr_q <= '0;
      pgnt_q      <= '0;
      sgnt_q      <= '0;
      busy_q      <= 1'b0;
      tmr_q       <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      snooper_q   <= snooper_d;
      proc_ptr_q  <= proc_ptr_d;
      snoop_ptr_q <= snoop_ptr_d;
      pgnt_q      <= pgnt_d;
      sgnt_q      <= sgnt_d;
      busy_q      <= |pgnt_d;
      tmr_q       <= tmr_d;
      timeout_q   <= timeout_d;
    end
  end

  generate
    for (genvar c = 0; c < NUM_CORES; c++) begin : g_gnt_map
      assign bus_lv1_lv2_gnt_proc_dl[c] = pgnt_q[2*c];
      assign bus_lv1_lv2_gnt_proc_il[c] = pgnt_q[2*c+1];
    end
  endgenerate

  assign bus_lv1_lv2_gnt_snoop = sgnt_q;
  assign bus_busy              = busy_q;
  assign arb_timeout           = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_arbiter_lv1_lv2.sv
// ============================================================================
// Module   : tb_arbiter_lv1_lv2
// Brief    : Self-checking bench for arbiter_lv1_lv2 with a behavioural model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arbiter_lv1_lv2;

  localparam int NC  = 4;
  localparam int NP  = 8;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NC-1:0] req_dl = '0;
  logic [NC-1:0] req_il = '0;
  logic [NC-1:0] req_sn = '0;
  logic [NC-1:0] gnt_dl, gnt_il, gnt_sn;
  logic          busy, tmo;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Model: owner/snooper as plain indices, -1 meaning none
  int m_owner = -1;
  int m_snp   = -1;
  int m_pptr  = 0;
  int m_sptr  = 0;
  int m_age   = 0;
  bit m_to    = 1'b0;

  arbiter_lv1_lv2 #(.NUM_CORES(NC), .TIMEOUT(TMO), .TMR_WID(11)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .bus_lv1_lv2_req_proc_dl (req_dl),
    .bus_lv1_lv2_req_proc_il (req_il),
    .bus_lv1_lv2_req_snoop   (req_sn),
    .bus_lv1_lv2_gnt_proc_dl (gnt_dl),
    .bus_lv1_lv2_gnt_proc_il (gnt_il),
    .bus_lv1_lv2_gnt_snoop   (gnt_sn),
    .bus_busy                (busy),
    .arb_timeout             (tmo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_idx(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [NP-1:0] flat_gnt();
    logic [NP-1:0] g;
    for (int c = 0; c < NC; c++) begin
      g[2*c]   = gnt_dl[c];
      g[2*c+1] = gnt_il[c];
    end
    return g;
  endfunction

  always @(posedge clk) begin : model
    logic [NP-1:0] preq;
    int  old_o, old_s, p, c;
    bit  found;
    for (int k = 0; k < NC; k++) begin
      preq[2*k]   = req_dl[k];
      preq[2*k+1] = req_il[k];
    end
    if (rst) begin
      m_owner = -1; m_snp = -1; m_pptr = 0; m_sptr = 0; m_age = 0; m_to = 1'b0;
    end else begin
      old_o = m_owner;
      old_s = m_snp;
      if (m_owner < 0) begin
        found = 1'b0;
        for (int i = 0; i < NP; i++) begin
          p = (m_pptr + i) % NP;
          if (!found && preq[p]) begin found = 1'b1; m_owner = p; end
        end
      end else if (!preq[m_owner]) begin
        m_pptr = (m_owner + 1) % NP;
        if (m_snp >= 0) m_sptr = (m_snp + 1) % NC;
        m_owner = -1;
        m_snp   = -1;
      end else if (m_snp < 0) begin
        found = 1'b0;
        for (int i = 0; i < NC; i++) begin
          c = (m_sptr + i) % NC;
          if (!found && req_sn[c] && !((m_owner % 2 == 0) && (m_owner / 2 == c))) begin
            found = 1'b1; m_snp = c;
          end
        end
      end else if (!req_sn[m_snp]) begin
        m_sptr = (m_snp + 1) % NC;
        m_snp  = -1;
      end
      if (m_owner != old_o || m_snp != old_s) m_age = 0;
      else if (m_owner >= 0 && m_age < TMO) m_age = m_age + 1;
      if (m_age == TMO) m_to = 1'b1;
    end
  end

  always @(negedge clk) begin : compare
    logic [NC-1:0] e_dl, e_il, e_sn;
    if (chk_en) begin
      for (int c = 0; c < NC; c++) begin
        e_dl[c] = (m_owner == 2*c);
        e_il[c] = (m_owner == 2*c + 1);
        e_sn[c] = (m_snp == c);
      end
      check("model_gnt_dl", gnt_dl, e_dl);
      check("model_gnt_il", gnt_il, e_il);
      check("model_gnt_snoop", gnt_sn, e_sn);
      check("model_busy", busy, (m_owner >= 0));
      check("model_timeout", tmo, m_to);
    end
  end

  task automatic do_reset();
    req_dl = '0; req_il = '0; req_sn = '0; rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_gnt_dl", gnt_dl, 0);
    check("rst_gnt_il", gnt_il, 0);
    check("rst_gnt_snoop", gnt_sn, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", tmo, 0);
    rst = 1'b0;
  endtask

  task automatic phase_single();
    int n;
    do_reset();
    req_il = 4'b0100;
    n = 0;
    while (gnt_il == 0 && n < 10) begin @(negedge clk); n++; end
    check("single_latency", n, 1);
    check("single_gnt_il", gnt_il, 4'b0100);
    check("single_busy", busy, 1);
    repeat (5) @(negedge clk);
    req_il = '0;
    @(negedge clk);
    check("single_release_gnt", gnt_il, 0);
    check("single_release_busy", busy, 0);
  endtask

  task automatic phase_fair();
    int order[$];
    int gaps;
    logic [NP-1:0] g, prev;
    do_reset();
    req_dl = '1; req_il = '1;
    prev = '0; gaps = 0;
    for (int cyc = 0; cyc < 60 && order.size() < 9; cyc++) begin
      @(negedge clk);
      g = flat_gnt();
      if (g != 0 && prev == 0) order.push_back(first_idx(32'(g)));
      else if (g == 0 && order.size() > 0) gaps++;
      req_dl = ~gnt_dl;
      req_il = ~gnt_il;
      prev = g;
    end
    check("fair_count", order.size(), 9);
    for (int i = 0; i < order.size(); i++) check("fair_order", order[i], i % NP);
    check("fair_idle_gaps", gaps, 8);
    req_dl = '0; req_il = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic phase_snoop();
    int order[$];
    bit core1_seen, owner_lost;
    logic [NC-1:0] prev;
    do_reset();
    req_dl = 4'b0010; req_sn = 4'b1111;
    prev = '0; core1_seen = 1'b0; owner_lost = 1'b0;
    for (int cyc = 0; cyc < 40 && order.size() < 3; cyc++) begin
      @(negedge clk);
      if (gnt_sn != 0 && prev == 0) order.push_back(first_idx(32'(gnt_sn)));
      if (gnt_sn[1]) core1_seen = 1'b1;
      if (cyc > 0 && gnt_dl != 4'b0010) owner_lost = 1'b1;
      prev   = gnt_sn;
      req_sn = 4'b1111 & ~gnt_sn;
    end
    check("snoop_count", order.size(), 3);
    if (order.size() == 3) begin
      check("snoop_order0", order[0], 0);
      check("snoop_order1", order[1], 2);
      check("snoop_order2", order[2], 3);
    end
    check("snoop_core1_never", core1_seen, 0);
    check("snoop_owner_held", owner_lost, 0);
    req_dl = '0; req_sn = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic phase_mid_release();
    int n;
    do_reset();
    req_il = 4'b0001; req_sn = 4'b0001;
    n = 0;
    while (gnt_sn == 0 && n < 10) begin @(negedge clk); n++; end
    check("midrel_snoop_core0", gnt_sn, 4'b0001);
    req_il = '0;
    @(negedge clk);
    check("midrel_gnt_il", gnt_il, 0);
    check("midrel_gnt_snoop", gnt_sn, 0);
    req_il = 4'b0001; req_sn = 4'b1111;
    n = 0;
    while (gnt_sn == 0 && n < 10) begin @(negedge clk); n++; end
    check("midrel_next_snoop", gnt_sn, 4'b0010);
    req_il = '0; req_sn = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic phase_watchdog();
    int n;
    do_reset();
    req_dl = 4'b1000;
    n = 0;
    while (gnt_dl == 0 && n < 10) begin @(negedge clk); n++; end
    check("wd_grant", gnt_dl, 4'b1000);
    n = 0;
    while (!tmo && n < 30) begin @(negedge clk); n++; end
    check("wd_delay", n, TMO);
    repeat (20 - n) @(negedge clk);
    req_dl = '0;
    repeat (3) @(negedge clk);
    check("wd_gnt_dropped", gnt_dl, 0);
    check("wd_sticky", tmo, 1);
  endtask

  task automatic phase_reset_mid();
    int n;
    do_reset();
    req_dl = 4'b0010; req_sn = 4'b0001;
    n = 0;
    while (gnt_sn == 0 && n < 10) begin @(negedge clk); n++; end
    check("rmid_in_snoop", gnt_sn, 4'b0001);
    rst = 1'b1;
    @(negedge clk);
    check("rmid_gnt_dl", gnt_dl, 0);
    check("rmid_gnt_snoop", gnt_sn, 0);
    check("rmid_busy", busy, 0);
    rst = 1'b0; req_dl = '1; req_il = '1; req_sn = '0;
    n = 0;
    while (gnt_dl == 0 && gnt_il == 0 && n < 10) begin @(negedge clk); n++; end
    check("rmid_first_dl0", gnt_dl, 4'b0001);
    check("rmid_first_il", gnt_il, 0);
    req_dl = '0; req_il = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic phase_random();
    bit cur, nxt;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 399) == 0) rst = 1'b1;
      for (int p = 0; p < NP; p++) begin
        cur = (p % 2 == 0) ? req_dl[p/2] : req_il[p/2];
        if (cur) nxt = (m_owner == p) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 29) != 0);
        else     nxt = ($urandom_range(0, 4) == 0);
        if (p % 2 == 0) req_dl[p/2] = nxt;
        else            req_il[p/2] = nxt;
      end
      for (int c = 0; c < NC; c++) begin
        if (req_sn[c]) req_sn[c] = (m_snp == c) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 19) != 0);
        else           req_sn[c] = ($urandom_range(0, 3) == 0);
      end
    end
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;
    phase_single();
    phase_fair();
    phase_snoop();
    phase_mid_release();
    phase_watchdog();
    phase_reset_mid();
    phase_random();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
